// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding fetch stage with 2-entry decode buffer; FETCH_PERF_CNT_EN adds fetch/flush counters
module instr_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [1:0]        fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [15:0]       flush_count
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  localparam logic [7:0] TO = 8'(TIMEOUT_CYCLES);
  state_t state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [7:0] cnt;
  logic drop, head, hs, pop, push, done, aligned;
  logic [1:0] count, push_flt;
  logic [DATA_W-1:0] push_ins;
  logic [ADDR_W-1:0] push_pc;
  logic [DATA_W-1:0] ins_q [2];
  logic [ADDR_W-1:0] pc_q [2];
  logic [1:0] flt_q [2];
  assign aligned = pc_in[1:0] == 2'b00;
  assign pc_ready = !rst && state == IDLE && count != 2'd2 && !flush && !drop;
  assign hs = pc_valid && pc_ready;
  assign instr_valid = count != 2'd0;
  assign pop = instr_valid && instr_ready;
  assign done = state == WAIT && (imem_rvalid || 8'(cnt + 8'd1) == TO);
  assign imem_req = state == REQ;
  assign imem_addr = addr;
  assign instr_out = ins_q[head];
  assign pc_out = pc_q[head];
  assign fault = flt_q[head];
  always_comb begin
    state_n = state == IDLE ? (hs && aligned ? REQ : IDLE)
            : state == REQ  ? (imem_gnt ? WAIT : REQ)
            : (done ? IDLE : WAIT);
    push = (hs && !aligned) || (done && !drop && !flush);
    push_ins = done && imem_rvalid ? imem_rdata : '0;
    push_pc = done ? addr : pc_in;
    push_flt = !done ? 2'b01 : imem_rvalid ? 2'b00 : 2'b10;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      cnt <= '0;
      drop <= 1'b0;
      count <= '0;
      head <= 1'b0;
      ins_q <= '{'0, '0};
      pc_q <= '{'0, '0};
      flt_q <= '{'0, '0};
    end else begin
      state <= state_n;
      if (hs && aligned) addr <= pc_in;
      cnt <= state == WAIT ? 8'(cnt + 8'd1) : 8'd0;
      drop <= done ? 1'b0 : (flush && state != IDLE) ? 1'b1 : drop;
      count <= flush ? 2'd0 : 2'(count + {1'b0, push} - {1'b0, pop});
      head <= head ^ (pop && !flush);
      // a push never meets a full buffer, so the tail slot is head offset by count
      if (push) begin
        ins_q[head ^ count[0]] <= push_ins;
        pc_q[head ^ count[0]] <= push_pc;
        flt_q[head ^ count[0]] <= push_flt;
      end
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      fetch_count <= fetch_count + 32'(pop);
      flush_count <= flush_count + 16'(flush);
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;
  localparam int TO = 4;
  logic clk = 0, rst = 1;
  logic [31:0] pc_in = 0, imem_rdata = 0;
  logic pc_valid = 0, flush = 0, imem_gnt = 0, imem_rvalid = 0, instr_ready = 0;
  logic pc_ready, imem_req, instr_valid;
  logic [31:0] imem_addr, instr_out, pc_out;
  logic [1:0] fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [15:0] flush_count;
`endif
  typedef struct packed {logic [31:0] ins; logic [31:0] pc; logic [1:0] flt;} ent_t;
  ent_t q[$];
  ent_t mon_e;
  int tests = 0, fails = 0;
  logic inflight = 0, granted = 0, dropped = 0, mode_to = 0;
  logic drain, exp_rdy, pop, push;
  int d = 0, waitc = 0, mcnt = 0;
  logic [31:0] mpc = 0, tmp;

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_out(instr_out), .pc_out(pc_out), .fault(fault)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (!rst && instr_valid && instr_ready) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL sb_extra: got pc=%h fault=%b, expected no output", pc_out, fault);
      end else begin
        mon_e = q.pop_front();
        if ({instr_out, pc_out, fault} !== mon_e) begin
          fails++;
          $display("FAIL sb_entry: got instr=%h pc=%h fault=%b expected instr=%h pc=%h fault=%b",
                   instr_out, pc_out, fault, mon_e.ins, mon_e.pc, mon_e.flt);
        end
      end
    end

  initial begin
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_pc_ready", pc_ready, 0);
    cyc();
    rst = 0;
    @(negedge clk);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_instr_out", instr_out, 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_fault", fault, 0);
    chk("rst_idle_ready", pc_ready, 1);
    // aligned fetch with minimal latency
    cyc();
    pc_valid = 1; pc_in = 32'h40;
    q.push_back('{32'h8C220004, 32'h40, 2'b00});
    @(negedge clk);
    chk("fetch_accept", pc_ready, 1);
    cyc();
    pc_valid = 0; imem_gnt = 1;
    @(negedge clk);
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, 32'h40);
    cyc();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h8C220004;
    @(negedge clk);
    chk("fetch_not_early", instr_valid, 0);
    cyc();
    imem_rvalid = 0; instr_ready = 1;
    @(negedge clk);
    chk("fetch_latency", instr_valid, 1);
    cyc();
    instr_ready = 0;
    @(negedge clk);
    chk("fetch_popped", instr_valid, 0);
    // misaligned pc
    cyc();
    pc_valid = 1; pc_in = 32'h42;
    q.push_back('{32'h0, 32'h42, 2'b01});
    cyc();
    pc_valid = 0; instr_ready = 1;
    @(negedge clk);
    chk("mis_no_req", imem_req, 0);
    chk("mis_valid", instr_valid, 1);
    cyc();
    instr_ready = 0;
    // timeout with no response, then a late response
    pc_valid = 1; pc_in = 32'h80;
    q.push_back('{32'h0, 32'h80, 2'b10});
    cyc();
    pc_valid = 0; imem_gnt = 1;
    cyc();
    imem_gnt = 0;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      chk("to_wait", instr_valid, 0);
      cyc();
    end
    instr_ready = 1;
    @(negedge clk);
    chk("to_fault_valid", instr_valid, 1);
    cyc();
    instr_ready = 0; imem_rvalid = 1; imem_rdata = 32'h12345678;
    cyc();
    imem_rvalid = 0;
    @(negedge clk);
    chk("late_rvalid_ignored", instr_valid, 0);
    chk("late_idle_ready", pc_ready, 1);
    // flush while waiting for a response
    cyc();
    pc_valid = 1; pc_in = 32'h100;
    cyc();
    pc_valid = 0; imem_gnt = 1;
    cyc();
    imem_gnt = 0; flush = 1;
    @(negedge clk);
    chk("flush_pc_ready", pc_ready, 0);
    cyc();
    flush = 0;
    @(negedge clk);
    chk("drop_pc_ready", pc_ready, 0);
    cyc();
    imem_rvalid = 1; imem_rdata = 32'hDEADBEEF;
    cyc();
    imem_rvalid = 0;
    @(negedge clk);
    chk("flush_dropped", instr_valid, 0);
    chk("flush_idle_ready", pc_ready, 1);
    // randomized traffic against the transaction-level model
    for (int n = 0; n < 3000; n++) begin
      drain = n >= 2900;
      cyc();
      pc_valid = !drain && ($urandom_range(0, 9) < 7);
      tmp = $urandom_range(0, 1023) * 4;
      if ($urandom_range(0, 4) == 0) tmp = tmp + $urandom_range(1, 3);
      pc_in = tmp;
      flush = !drain && ($urandom_range(0, 24) == 0);
      instr_ready = drain || ($urandom_range(0, 9) < 6);
      imem_gnt = $urandom_range(0, 1) == 1;
      imem_rvalid = (inflight && granted) ? (!mode_to && waitc == d) : ($urandom_range(0, 9) == 0);
      imem_rdata = $urandom;
      #6;
      exp_rdy = !inflight && mcnt < 2 && !flush;
      chk("pc_ready", pc_ready, exp_rdy);
      chk("instr_valid", instr_valid, mcnt != 0);
      chk("imem_req", imem_req, inflight && !granted);
      pop = instr_ready && mcnt != 0;
      push = 0;
      if (flush) begin
        q.delete();
        if (inflight) dropped = 1;
      end
      if (inflight && granted) begin
        if (imem_rvalid || (mode_to && waitc == TO - 1)) begin
          if (!dropped) begin
            q.push_back(imem_rvalid ? ent_t'{imem_rdata, mpc, 2'b00} : ent_t'{32'h0, mpc, 2'b10});
            push = 1;
          end
          inflight = 0;
        end else waitc++;
      end else if (inflight && imem_gnt) begin
        chk("imem_addr", imem_addr, mpc);
        granted = 1;
        waitc = 0;
        mode_to = $urandom_range(0, 6) == 0;
        d = $urandom_range(0, TO - 1);
      end
      if (pc_valid && exp_rdy) begin
        if (pc_in[1:0] != 2'b00) begin
          q.push_back('{32'h0, pc_in, 2'b01});
          push = 1;
        end else begin
          inflight = 1; granted = 0; dropped = 0; mpc = pc_in;
        end
      end
      mcnt = flush ? 0 : mcnt + int'(push) - int'(pop);
    end
    @(negedge clk);
    chk("drain_empty", q.size(), 0);
    chk("drain_valid", instr_valid, 0);
    // reset while a request is pending
    cyc();
    pc_valid = 1; pc_in = 32'h300; imem_gnt = 0; flush = 0; instr_ready = 0; imem_rvalid = 0;
    cyc();
    pc_valid = 0;
    @(negedge clk);
    chk("rreq_req", imem_req, 1);
    cyc();
    rst = 1;
    @(negedge clk);
    chk("rreq_rst_ready", pc_ready, 0);
    cyc();
    rst = 0;
    @(negedge clk);
    chk("rreq_req_dropped", imem_req, 0);
    chk("rreq_valid", instr_valid, 0);
    chk("rreq_idle", pc_ready, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage placed directly downstream of the program-counter stage.
- Accepts each PC value through a valid/ready handshake and issues a single-outstanding request to instruction memory.
- Buffers returned instruction words in a 2-entry FIFO and presents {instruction, pc, fault} to decode through a valid/ready handshake.
- Supports pipeline flush (branch/jump redirect), misaligned-PC detection and a memory-response timeout.

Parameters:
- ADDR_W, 32, PC / memory address width.
- DATA_W, 32, instruction word width.
- TIMEOUT_CYCLES, 255, cycles spent in WAIT before a bus-timeout fault is raised (8-bit counter; legal range 1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_in  in  ADDR_W  PC from the PC stage.
- pc_valid  in  1  pc_in is valid.
- pc_ready  out  1  fetch unit accepts pc_in this cycle.
- flush  in  1  discard buffered and in-flight fetches.
- imem_req  out  1  memory request; held until granted.
- imem_addr  out  ADDR_W  request address (word aligned).
- imem_gnt  in  1  memory accepts the request.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  DATA_W  response data.
- instr_valid  out  1  head FIFO entry is valid.
- instr_ready  in  1  decode consumes the head entry.
- instr_out  out  DATA_W  head instruction.
- pc_out  out  ADDR_W  PC of the head instruction.
- fault  out  2  00 none, 01 misaligned PC, 10 bus timeout.

Behaviour:
- All state updates on the rising edge of clk. rst is synchronous and active-high, and it overrides everything.
- Reset values:
  - state=IDLE.
  - FIFO count=0.
  - imem_req=0, imem_addr=0.
  - instr_valid=0, instr_out=0, pc_out=0, fault=00.
  - drop flag=0, timeout counter=0.
  - pc_ready=0 during reset.
- FSM states:
  - IDLE:
    - pc_ready = (count<2) && !flush && !drop.
    - A handshake (pc_valid && pc_ready) with pc_in[1:0]==0 latches the address and moves to REQ.
    - A handshake with pc_in[1:0]!=0 pushes {instr=0, pc=pc_in, fault=01} into the FIFO on that edge and stays in IDLE. No memory request is issued.
  - REQ:
    - imem_req=1 and imem_addr=latched PC.
    - imem_req is never withdrawn before imem_gnt, even if flush is asserted.
    - On imem_gnt, go to WAIT and clear the timeout counter.
  - WAIT:
    - The counter increments each cycle.
    - On imem_rvalid, push {imem_rdata, latched PC, 00} unless drop=1. Then go to IDLE and clear drop.
    - If the counter reaches TIMEOUT_CYCLES without rvalid, push {0, latched PC, 10} unless drop=1, then go to IDLE.
- Stray imem_rvalid seen in IDLE or REQ is ignored.
- Latency: PC accepted at edge T → imem_req high in cycle T+1. With gnt at T+1 and rvalid at T+2, instr_valid is high in cycle T+3. Misaligned-PC fault: instr_valid in cycle T+1.
- FIFO:
  - 2 entries.
  - instr_valid = count!=0.
  - Pop when instr_valid && instr_ready.
  - A push and a pop in the same cycle are legal and leave count unchanged.
  - Because count<2 is required at acceptance and only one request is outstanding, a push never meets a full FIFO.
  - Outputs are taken from the head entry and are stable while instr_valid && !instr_ready.
- Flush:
  - Empties the FIFO on the same edge; instr_valid=0 in the next cycle.
  - In REQ or WAIT, sets drop=1. The request completes on the bus, its response (or timeout) is discarded, and pc_ready stays low until the state returns to IDLE.
  - A flush in the same cycle as pc_valid means no handshake takes place; flush wins.
  - A flush in IDLE with no request in flight only clears the FIFO.
- Reset in mid-operation abandons any request immediately (imem_req=0 the next cycle). The memory side is reset together with this unit.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds output ports fetch_count[31:0] and flush_count[15:0], both reset to 0 and wrapping on overflow:
  - fetch_count increments on every FIFO pop.
  - flush_count increments on every cycle in which flush=1.
- When undefined, these ports and counters do not exist, and the remaining behaviour is identical.

Test Plan:
- Aligned fetch: pc_in=0x00000040 accepted at T, gnt at T+1, rvalid at T+2 with rdata=0x8C220004 → instr_valid at T+3 with instr_out=0x8C220004, pc_out=0x40, fault=00.
- Back-pressure: instr_ready=0 and three aligned PCs 0x0, 0x4, 0x8 offered → two entries buffered, then pc_ready=0. Raising instr_ready → popped in order 0x0, 0x4, after which 0x8 is accepted.
- Misaligned PC: pc_in=0x00000042 → no imem_req, and in the next cycle instr_valid=1, fault=01, pc_out=0x42, instr_out=0.
- Flush in WAIT: flush after gnt for pc 0x100, then rvalid with rdata=0xDEADBEEF → nothing pushed, pc_ready low until IDLE. A subsequent pc 0x200 fetches normally.
- Timeout: gnt given, rvalid never asserted, TIMEOUT_CYCLES=4 → entry with fault=10 and pc_out equal to the request address after 4 WAIT cycles. A late rvalid is ignored.
- Reset in REQ with imem_gnt held low → imem_req=0, instr_valid=0, state IDLE the cycle after rst.
